shift_issue_stage: RTL and testbench

//  ID->EX issue register for the shift datapath. Decodes MIPS R-type shift instructions into the

---
 rtl/shift_issue_stage.sv | 204 ++++++++++++++++++++
 tb/tb_shift_issue_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
// ----------------------------------------------------------------------------
// shift_issue_stage
//
// ID->EX issue register for the shift datapath. Decodes MIPS R-type shift
// instructions (SLL/SRL/SRA, their variable forms, and optionally ROTR/ROTRV)
// into barrel-shifter controls. Forwards rs/rt from MEM and WB, stalls on a
// load-use hazard and holds one entry behind a valid/ready handshake.
//
// Parameters
//   RESET_SEL  Shift_sel value after reset and for non-shift entries
//   ROTATE_EN  1: decode ROTR/ROTRV, 0: rotate bits are not honoured
//
// Ports
//   Clk, Reset                     clock, synchronous active-high reset
//   In_valid / In_ready            upstream handshake
//   Instr, Rs_data, Rt_data        instruction word and register-file reads
//   Fwd_mem_* / Fwd_wb_*           MEM / WB write-back forwarding sources
//   Load_ex_valid, Load_ex_reg     load in EX, for load-use detection
//   Flush                          kill held entry and current input
//   Out_valid / Out_ready          downstream handshake
//   Shift_data, Shift_count,
//   Shift_sel, Shift_en, Shift_rd,
//   Illegal                        registered shifter controls
// ----------------------------------------------------------------------------
module shift_issue_stage #(
    parameter logic [1:0] RESET_SEL = 2'b00,
    parameter bit         ROTATE_EN = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic [31:0] Instr,
    input  logic [31:0] Rs_data,
    input  logic [31:0] Rt_data,
    input  logic        Fwd_mem_we,
    input  logic [4:0]  Fwd_mem_reg,
    input  logic [31:0] Fwd_mem_data,
    input  logic        Fwd_wb_we,
    input  logic [4:0]  Fwd_wb_reg,
    input  logic [31:0] Fwd_wb_data,
    input  logic        Load_ex_valid,
    input  logic [4:0]  Load_ex_reg,
    input  logic        Flush,
    output logic        Out_valid,
    input  logic        Out_ready,
    output logic [31:0] Shift_data,
    output logic [4:0]  Shift_count,
    output logic [1:0]  Shift_sel,
    output logic        Shift_en,
    output logic [4:0]  Shift_rd,
    output logic        Illegal
);

    localparam logic [1:0] SEL_SLL  = 2'b00;
    localparam logic [1:0] SEL_SRL  = 2'b01;
    localparam logic [1:0] SEL_SRA  = 2'b10;
    localparam logic [1:0] SEL_ROTR = 2'b11;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs_idx;
    logic [4:0] rt_idx;

    assign opcode = Instr[31:26];
    assign funct  = Instr[5:0];
    assign rs_idx = Instr[25:21];
    assign rt_idx = Instr[20:16];

    // ---------------- forwarding ----------------
    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rs_fwd = Rs_data;
        if (rs_idx != 5'd0) begin
            if (Fwd_mem_we && Fwd_mem_reg == rs_idx)     rs_fwd = Fwd_mem_data;
            else if (Fwd_wb_we && Fwd_wb_reg == rs_idx)  rs_fwd = Fwd_wb_data;
        end
    end

    always_comb begin
        rt_fwd = Rt_data;
        if (rt_idx != 5'd0) begin
            if (Fwd_mem_we && Fwd_mem_reg == rt_idx)     rt_fwd = Fwd_mem_data;
            else if (Fwd_wb_we && Fwd_wb_reg == rt_idx)  rt_fwd = Fwd_wb_data;
        end
    end

    // Only the low five bits of rs form a variable count.
    logic unused_rs_hi;
    assign unused_rs_hi = ^rs_fwd[31:5];

    // ---------------- decode ----------------
    logic       dec_en;
    logic       dec_illegal;
    logic [4:0] dec_count;
    logic [1:0] dec_sel;

    always_comb begin
        dec_en      = 1'b0;
        dec_illegal = 1'b0;
        dec_count   = 5'd0;
        dec_sel     = RESET_SEL;
        if (opcode == 6'd0) begin
            unique case (funct)
                // Immediate forms: rs field must be zero, except Instr[21]
                // which selects rotate on SRL.
                6'b000000, 6'b000010, 6'b000011: begin
                    if (Instr[25:22] != 4'd0 || (Instr[21] && !ROTATE_EN)) begin
                        dec_illegal = 1'b1;
                    end else begin
                        dec_en    = 1'b1;
                        dec_count = Instr[10:6];
                        case (funct)
                            6'b000000: dec_sel = SEL_SLL;
                            6'b000010: dec_sel = (ROTATE_EN && Instr[21]) ? SEL_ROTR : SEL_SRL;
                            default:   dec_sel = SEL_SRA;
                        endcase
                    end
                end
                // Variable forms: shamt[4:1] must be zero, Instr[6] selects
                // rotate on SRLV.
                6'b000100, 6'b000110, 6'b000111: begin
                    if (Instr[10:7] != 4'd0) begin
                        dec_illegal = 1'b1;
                    end else begin
                        dec_en    = 1'b1;
                        dec_count = rs_fwd[4:0];
                        case (funct)
                            6'b000100: dec_sel = SEL_SLL;
                            6'b000110: dec_sel = (ROTATE_EN && Instr[6]) ? SEL_ROTR : SEL_SRL;
                            default:   dec_sel = SEL_SRA;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- handshake ----------------
    logic hazard;
    logic accept;
    logic out_valid_q;
    logic out_valid_d;

    assign hazard = In_valid && Load_ex_valid && (Load_ex_reg != 5'd0) &&
                    (Load_ex_reg == rs_idx || Load_ex_reg == rt_idx);
    assign In_ready = !hazard && (!out_valid_q || Out_ready);
    assign accept   = In_valid && In_ready && !Flush;

    // Flush beats everything; a drain with a simultaneous accept keeps valid
    // high so back-to-back entries flow without a bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        if (Flush)                         out_valid_d = 1'b0;
        else if (accept)                   out_valid_d = 1'b1;
        else if (out_valid_q && Out_ready) out_valid_d = 1'b0;
    end

    // ---------------- entry register ----------------
    logic [31:0] shift_data_q;
    logic [4:0]  shift_count_q;
    logic [1:0]  shift_sel_q;
    logic        shift_en_q;
    logic [4:0]  shift_rd_q;
    logic        illegal_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_q   <= 1'b0;
            shift_data_q  <= 32'd0;
            shift_count_q <= 5'd0;
            shift_sel_q   <= RESET_SEL;
            shift_en_q    <= 1'b0;
            shift_rd_q    <= 5'd0;
            illegal_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                shift_data_q  <= rt_fwd;
                shift_count_q <= dec_count;
                shift_sel_q   <= dec_sel;
                shift_en_q    <= dec_en;
                shift_rd_q    <= Instr[15:11];
                illegal_q     <= dec_illegal;
            end
        end
    end

    assign Out_valid   = out_valid_q;
    assign Shift_data  = shift_data_q;
    assign Shift_count = shift_count_q;
    assign Shift_sel   = shift_sel_q;
    assign Shift_en    = shift_en_q;
    assign Shift_rd    = shift_rd_q;
    assign Illegal     = illegal_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// ----------------------------------------------------------------------------
// tb_shift_issue_stage
//
// Directed bench for shift_issue_stage: a table of single-cycle decode and
// forwarding vectors, then hand-written sequences for load-use stall,
// output back-pressure, flush and reset during a held entry.
// ----------------------------------------------------------------------------
module tb_shift_issue_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        In_valid;
    logic        In_ready;
    logic [31:0] Instr;
    logic [31:0] Rs_data;
    logic [31:0] Rt_data;
    logic        Fwd_mem_we;
    logic [4:0]  Fwd_mem_reg;
    logic [31:0] Fwd_mem_data;
    logic        Fwd_wb_we;
    logic [4:0]  Fwd_wb_reg;
    logic [31:0] Fwd_wb_data;
    logic        Load_ex_valid;
    logic [4:0]  Load_ex_reg;
    logic        Flush;
    logic        Out_valid;
    logic        Out_ready;
    logic [31:0] Shift_data;
    logic [4:0]  Shift_count;
    logic [1:0]  Shift_sel;
    logic        Shift_en;
    logic [4:0]  Shift_rd;
    logic        Illegal;

    shift_issue_stage #(.RESET_SEL(2'b00), .ROTATE_EN(1'b1)) dut (
        .Clk(Clk), .Reset(Reset),
        .In_valid(In_valid), .In_ready(In_ready),
        .Instr(Instr), .Rs_data(Rs_data), .Rt_data(Rt_data),
        .Fwd_mem_we(Fwd_mem_we), .Fwd_mem_reg(Fwd_mem_reg), .Fwd_mem_data(Fwd_mem_data),
        .Fwd_wb_we(Fwd_wb_we), .Fwd_wb_reg(Fwd_wb_reg), .Fwd_wb_data(Fwd_wb_data),
        .Load_ex_valid(Load_ex_valid), .Load_ex_reg(Load_ex_reg),
        .Flush(Flush),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Shift_data(Shift_data), .Shift_count(Shift_count), .Shift_sel(Shift_sel),
        .Shift_en(Shift_en), .Shift_rd(Shift_rd), .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic        mem_we;
        logic [4:0]  mem_reg;
        logic [31:0] mem_data;
        logic        wb_we;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic [31:0] e_data;
        logic [4:0]  e_count;
        logic [1:0]  e_sel;
        logic        e_en;
        logic [4:0]  e_rd;
        logic        e_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    task automatic check_entry(input string tag, input logic [31:0] data, input logic [4:0] cnt,
                               input logic [1:0] sel, input logic en, input logic [4:0] rd,
                               input logic ill);
        check({tag, ".valid"}, 32'(Out_valid),   32'd1);
        check({tag, ".data"},  Shift_data,       data);
        check({tag, ".count"}, 32'(Shift_count), 32'(cnt));
        check({tag, ".sel"},   32'(Shift_sel),   32'(sel));
        check({tag, ".en"},    32'(Shift_en),    32'(en));
        check({tag, ".rd"},    32'(Shift_rd),    32'(rd));
        check({tag, ".ill"},   32'(Illegal),     32'(ill));
    endtask

    initial begin
        // name, instr, rs, rt, mem_we, mem_reg, mem_data, wb_we, wb_reg, wb_data,
        //   exp data, count, sel, en, rd, illegal
        vecs.push_back('{"sll_imm",   32'h0002_1900,       32'h0, 32'hF1,  1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,
                         32'hF1,   5'd4,  2'b00, 1'b1, 5'd3,  1'b0});
        vecs.push_back('{"srav_mem",  rtype(6,5,4,0,7),    32'h123, 32'h8000_0000, 1'b1, 5'd6, 32'h21, 1'b0, 5'd0, 32'h0,
                         32'h8000_0000, 5'd1, 2'b10, 1'b1, 5'd4, 1'b0});
        vecs.push_back('{"srl_mem_wb", rtype(0,7,1,8,2),   32'h0, 32'h1111, 1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB,
                         32'hAAAA, 5'd8,  2'b01, 1'b1, 5'd1,  1'b0});
        vecs.push_back('{"sll_r0",    rtype(0,0,9,31,0),   32'h0, 32'h1234, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF,
                         32'h1234, 5'd31, 2'b00, 1'b1, 5'd9,  1'b0});
        vecs.push_back('{"rotr",      rtype(1,2,5,3,2),    32'h0, 32'h55,  1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,
                         32'h55,   5'd3,  2'b11, 1'b1, 5'd5,  1'b0});
        vecs.push_back('{"rotrv_mod", rtype(3,4,6,1,6),    32'h3F, 32'h77, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,
                         32'h77,   5'd31, 2'b11, 1'b1, 5'd6,  1'b0});
        vecs.push_back('{"sllv_wb",   rtype(8,9,10,0,4),   32'h99, 32'h66, 1'b0, 5'd0,  32'h0,    1'b1, 5'd8,  32'h25,
                         32'h66,   5'd5,  2'b00, 1'b1, 5'd10, 1'b0});
        vecs.push_back('{"sra_wb_rt", rtype(0,11,12,2,3),  32'h0, 32'h1,   1'b1, 5'd12, 32'hFFFF, 1'b1, 5'd11, 32'hCAFE,
                         32'hCAFE, 5'd2,  2'b10, 1'b1, 5'd12, 1'b0});
        vecs.push_back('{"ill_imm",   rtype(4,2,13,5,0),   32'h0, 32'h10,  1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,
                         32'h10,   5'd0,  2'b00, 1'b0, 5'd13, 1'b1});
        vecs.push_back('{"ill_var",   rtype(1,2,14,2,7),   32'h3, 32'h20,  1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,
                         32'h20,   5'd0,  2'b00, 1'b0, 5'd14, 1'b1});
        vecs.push_back('{"add_nonsh", rtype(1,2,15,0,32),  32'h0, 32'h30,  1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,
                         32'h30,   5'd0,  2'b00, 1'b0, 5'd15, 1'b0});
        vecs.push_back('{"opc_nz",    32'h2000_0000 | rtype(0,2,16,4,0), 32'h0, 32'h40, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                         32'h40,   5'd0,  2'b00, 1'b0, 5'd16, 1'b0});
        vecs.push_back('{"srlv",      rtype(5,6,17,0,6),   32'h24, 32'h8,  1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,
                         32'h8,    5'd4,  2'b01, 1'b1, 5'd17, 1'b0});

        Reset = 1'b1; In_valid = 1'b0; Instr = '0; Rs_data = '0; Rt_data = '0;
        Fwd_mem_we = 1'b0; Fwd_mem_reg = '0; Fwd_mem_data = '0;
        Fwd_wb_we = 1'b0; Fwd_wb_reg = '0; Fwd_wb_data = '0;
        Load_ex_valid = 1'b0; Load_ex_reg = '0; Flush = 1'b0; Out_ready = 1'b1;

        // ---- reset state ----
        step(); step();
        check("rst.valid", 32'(Out_valid),   32'd0);
        check("rst.data",  Shift_data,       32'd0);
        check("rst.count", 32'(Shift_count), 32'd0);
        check("rst.sel",   32'(Shift_sel),   32'd0);
        check("rst.en",    32'(Shift_en),    32'd0);
        check("rst.rd",    32'(Shift_rd),    32'd0);
        check("rst.ill",   32'(Illegal),     32'd0);
        Reset = 1'b0;
        #1 check("rst.in_ready", 32'(In_ready), 32'd1);

        // ---- table: one accepted entry per cycle with Out_ready=1 ----
        foreach (vecs[i]) begin
            In_valid     = 1'b1;
            Instr        = vecs[i].instr;
            Rs_data      = vecs[i].rs_data;
            Rt_data      = vecs[i].rt_data;
            Fwd_mem_we   = vecs[i].mem_we;
            Fwd_mem_reg  = vecs[i].mem_reg;
            Fwd_mem_data = vecs[i].mem_data;
            Fwd_wb_we    = vecs[i].wb_we;
            Fwd_wb_reg   = vecs[i].wb_reg;
            Fwd_wb_data  = vecs[i].wb_data;
            step();
            check_entry(vecs[i].name, vecs[i].e_data, vecs[i].e_count, vecs[i].e_sel,
                        vecs[i].e_en, vecs[i].e_rd, vecs[i].e_ill);
        end
        In_valid = 1'b0; Fwd_mem_we = 1'b0; Fwd_wb_we = 1'b0;
        Rs_data = '0; Rt_data = '0;
        step();
        check("drain.valid", 32'(Out_valid), 32'd0);

        // ---- load-use hazard ----
        In_valid = 1'b1; Instr = rtype(3,4,20,0,4);
        Load_ex_valid = 1'b1; Load_ex_reg = 5'd3;
        #1 check("haz_rs.in_ready", 32'(In_ready), 32'd0);
        Instr = rtype(0,2,18,6,2); Rt_data = 32'h100; Load_ex_reg = 5'd2;
        #1 check("haz_rt.in_ready", 32'(In_ready), 32'd0);
        step();
        check("haz.no_accept", 32'(Out_valid), 32'd0);
        Load_ex_valid = 1'b0;
        #1 check("haz.release", 32'(In_ready), 32'd1);
        step();
        check_entry("haz.entry", 32'h100, 5'd6, 2'b01, 1'b1, 5'd18, 1'b0);

        // Load to r0 never stalls.
        Instr = rtype(0,0,19,7,0); Rt_data = 32'hABC;
        Load_ex_valid = 1'b1; Load_ex_reg = 5'd0;
        #1 check("haz_r0.in_ready", 32'(In_ready), 32'd1);
        step();
        check_entry("haz_r0.entry", 32'hABC, 5'd7, 2'b00, 1'b1, 5'd19, 1'b0);
        Load_ex_valid = 1'b0;

        // ---- back-pressure: hold 3 cycles, then back-to-back ----
        Out_ready = 1'b0;
        Instr = rtype(0,5,21,9,3); Rt_data = 32'h5;
        for (int c = 0; c < 3; c++) begin
            #1 check("stall.in_ready", 32'(In_ready), 32'd0);
            step();
            check_entry("stall.hold", 32'hABC, 5'd7, 2'b00, 1'b1, 5'd19, 1'b0);
        end
        Out_ready = 1'b1;
        #1 check("b2b.in_ready", 32'(In_ready), 32'd1);
        step();
        check_entry("b2b.e2", 32'h5, 5'd9, 2'b10, 1'b1, 5'd21, 1'b0);
        Instr = rtype(0,6,22,10,0); Rt_data = 32'h6;
        step();
        check_entry("b2b.e3", 32'h6, 5'd10, 2'b00, 1'b1, 5'd22, 1'b0);

        // ---- flush with held entry and accepting input ----
        Instr = rtype(0,7,23,11,2); Rt_data = 32'h7; Flush = 1'b1;
        step();
        check("flush.valid", 32'(Out_valid), 32'd0);
        Flush = 1'b0;
        step();
        check_entry("flush.after", 32'h7, 5'd11, 2'b01, 1'b1, 5'd23, 1'b0);
        // Flush wins over a stalled entry too.
        Out_ready = 1'b0; Flush = 1'b1;
        step();
        check("flush_stall.valid", 32'(Out_valid), 32'd0);
        Flush = 1'b0; Out_ready = 1'b1;

        // ---- reset while an entry is held ----
        Instr = rtype(0,8,24,12,3); Rt_data = 32'h9;
        step();
        check_entry("rsthold.entry", 32'h9, 5'd12, 2'b10, 1'b1, 5'd24, 1'b0);
        Out_ready = 1'b0;
        Reset = 1'b1;
        step();
        check("rsthold.valid", 32'(Out_valid),   32'd0);
        check("rsthold.data",  Shift_data,       32'd0);
        check("rsthold.count", 32'(Shift_count), 32'd0);
        check("rsthold.sel",   32'(Shift_sel),   32'd0);
        check("rsthold.en",    32'(Shift_en),    32'd0);
        check("rsthold.rd",    32'(Shift_rd),    32'd0);
        Reset = 1'b0; In_valid = 1'b0; Out_ready = 1'b1;
        step();
        check("rsthold.idle", 32'(Out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
